sia_rx_ctrl: RTL and testbench

SIA_RX_CTRL -- requirements
Module: sia_rx_ctrl

---
 rtl/sia_pkg.sv | 36 +++
 rtl/sia_fifo.sv | 72 +++++++
 rtl/sia_rx_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_sia_rx_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sia_pkg.sv
// Shared definitions for the SIA receive controller: register map,
// CTRL field positions, CTRL reset value and the BITS saturation helper.
package sia_pkg;

  // Wishbone register addresses
  localparam logic [2:0] ADR_CTRL   = 3'd0;
  localparam logic [2:0] ADR_BAUDL  = 3'd1;
  localparam logic [2:0] ADR_BAUDH  = 3'd2;
  localparam logic [2:0] ADR_DATA   = 3'd3;
  localparam logic [2:0] ADR_STATUS = 3'd4;

  // CTRL field positions
  localparam int CTRL_BITS_LSB = 0;
  localparam int CTRL_BITS_MSB = 4;
  localparam int CTRL_EEDD_BIT = 5;
  localparam int CTRL_EEDC_BIT = 6;
  localparam int CTRL_EN_BIT   = 7;
  localparam int CTRL_IE_BIT   = 8;

  // CTRL reset: BITS=10, EEDD=1, EEDC=0, EN=0, IE=0
  localparam logic [15:0] CTRL_RST = 16'h002A;

  // STATUS field positions
  localparam int STATUS_NE_BIT   = 0;
  localparam int STATUS_FULL_BIT = 1;
  localparam int STATUS_OVR_BIT  = 2;
  localparam int STATUS_BUSY_BIT = 3;

  // Largest frame length the shift register can hold
  localparam logic [4:0] BITS_MAX = 5'd16;

  function automatic logic [4:0] sat_bits(input logic [4:0] b);
    return (b > BITS_MAX) ? BITS_MAX : b;
  endfunction

endpackage

// File: rtl/sia_fifo.sv
// Synchronous receive FIFO.
// Ports: clk_i, reset_ni (async active-low); push_i/wdata_i write side;
// pop_i/rdata_o read side (rdata_o shows the head, valid when !empty_o);
// full_o, empty_o, count_o occupancy. A push while full is accepted only
// when a pop happens in the same cycle.
module sia_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    do_push  = push_i & (~full_o | pop_i);
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, and leaving the array out of reset lets it map
  // onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sia_rx_ctrl.sv
// SIA receive controller: Wishbone B4 pipelined register slave that
// configures a serial receiver, captures each finished frame from the
// receiver's raw shift register into a FIFO and raises a level interrupt.
// Ports:
//   clk_i, reset_ni            clock, async active-low reset
//   cyc_i, stb_i, we_i, adr_i, dat_i, ack_o, dat_o, stall_o   Wishbone slave
//   rx_bits_o, rx_baud_o, rx_eedd_o, rx_eedc_o, rx_reset_o   receiver config
//   rx_dat_i, rx_idle_i        receiver shift register and idle flag
//   irq_o                      level interrupt (IE & FIFO not empty)
module sia_rx_ctrl
  import sia_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SRW_BITS   = 16
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [2:0]          adr_i,
  input  logic [15:0]         dat_i,
  output logic                ack_o,
  output logic [15:0]         dat_o,
  output logic                stall_o,
  output logic [4:0]          rx_bits_o,
  output logic [31:0]         rx_baud_o,
  output logic                rx_eedd_o,
  output logic                rx_eedc_o,
  output logic                rx_reset_o,
  input  logic [SRW_BITS-1:0] rx_dat_i,
  input  logic                rx_idle_i,
  output logic                irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        ack_q, ack_d;
  logic [15:0] dat_q, dat_d;
  logic [4:0]  bits_q, bits_d;
  logic        eedd_q, eedd_d;
  logic        eedc_q, eedc_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic [31:0] baud_q, baud_d;
  logic        ovr_q, ovr_d;
  logic        idle_q;
  logic        irq_q, irq_d;

  logic          acc, wr, rd;
  logic          capture, push, pop, ovf, ovr_clr;
  logic [15:0]   frame;
  logic [15:0]   fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [15:0]   ctrl_rd, status_rd;

  // Right-align an N-bit frame (start bit in bit 0, stop bit in bit N-1)
  // and reduce it to {FE, data}. Frames shorter than 3 bits have no room
  // for data and are always flagged as framing errors.
  function automatic logic [15:0] decode_frame(input logic [SRW_BITS-1:0] raw,
                                               input logic [4:0]          n);
    logic [SRW_BITS-1:0] aligned;
    logic [SRW_BITS-1:0] mask;
    logic [SRW_BITS-1:0] field;
    logic                start_b;
    logic                stop_b;
    aligned = raw >> (SRW_BITS - int'(n));
    mask    = (SRW_BITS'(1) << (n - 5'd2)) - SRW_BITS'(1);
    start_b = aligned[0];
    stop_b  = |(aligned & (SRW_BITS'(1) << (n - 5'd1)));
    field   = (aligned >> 1) & mask;
    if (n < 5'd3) return 16'h8000;
    return {start_b | ~stop_b, field[14:0]};
  endfunction

  sia_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (push),
    .wdata_i  (frame),
    .pop_i    (pop),
    .rdata_o  (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign stall_o    = 1'b0;
  assign ack_o      = ack_q;
  assign dat_o      = dat_q;
  assign irq_o      = irq_q;
  assign rx_bits_o  = bits_q;
  assign rx_baud_o  = baud_q;
  assign rx_eedd_o  = eedd_q;
  assign rx_eedc_o  = eedc_q;
  assign rx_reset_o = ~en_q;

  always_comb begin
    acc = cyc_i & stb_i;
    wr  = acc & we_i;
    rd  = acc & ~we_i;

    // A frame completes on the rising edge of rx_idle_i, seen against the
    // previous-cycle copy; a receiver held in reset never delivers frames.
    capture = rx_idle_i & ~idle_q & ~rx_reset_o;
    frame   = decode_frame(rx_dat_i, bits_q);
    pop     = rd & (adr_i == ADR_DATA) & ~fifo_empty;
    // A simultaneous pop frees the slot, so a full FIFO still takes the frame.
    push    = capture & (~fifo_full | pop);
    ovf     = capture & fifo_full & ~pop;
    ovr_clr = wr & (adr_i == ADR_STATUS) & dat_i[STATUS_OVR_BIT];
    // A new overflow wins over a clear in the same cycle.
    ovr_d   = (ovr_q & ~ovr_clr) | ovf;

    ctrl_rd = '0;
    ctrl_rd[CTRL_BITS_MSB:CTRL_BITS_LSB] = bits_q;
    ctrl_rd[CTRL_EEDD_BIT] = eedd_q;
    ctrl_rd[CTRL_EEDC_BIT] = eedc_q;
    ctrl_rd[CTRL_EN_BIT]   = en_q;
    ctrl_rd[CTRL_IE_BIT]   = ie_q;

    status_rd = '0;
    status_rd[STATUS_NE_BIT]   = ~fifo_empty;
    status_rd[STATUS_FULL_BIT] = fifo_full;
    status_rd[STATUS_OVR_BIT]  = ovr_q;
    status_rd[STATUS_BUSY_BIT] = ~rx_idle_i;

    ack_d = acc;
    dat_d = '0;
    if (rd) begin
      case (adr_i)
        ADR_CTRL:   dat_d = ctrl_rd;
        ADR_BAUDL:  dat_d = baud_q[15:0];
        ADR_BAUDH:  dat_d = baud_q[31:16];
        ADR_DATA:   dat_d = fifo_empty ? 16'h0000 : fifo_head;
        ADR_STATUS: dat_d = status_rd;
        default:    dat_d = '0;
      endcase
    end

    bits_d = bits_q;
    eedd_d = eedd_q;
    eedc_d = eedc_q;
    en_d   = en_q;
    ie_d   = ie_q;
    baud_d = baud_q;
    if (wr) begin
      case (adr_i)
        ADR_CTRL: begin
          bits_d = sat_bits(dat_i[CTRL_BITS_MSB:CTRL_BITS_LSB]);
          eedd_d = dat_i[CTRL_EEDD_BIT];
          eedc_d = dat_i[CTRL_EEDC_BIT];
          en_d   = dat_i[CTRL_EN_BIT];
          ie_d   = dat_i[CTRL_IE_BIT];
        end
        ADR_BAUDL: baud_d[15:0]  = dat_i;
        ADR_BAUDH: baud_d[31:16] = dat_i;
        default:   ;
      endcase
    end

    irq_d = ie_q & (fifo_count != '0);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      bits_q <= CTRL_RST[CTRL_BITS_MSB:CTRL_BITS_LSB];
      eedd_q <= CTRL_RST[CTRL_EEDD_BIT];
      eedc_q <= CTRL_RST[CTRL_EEDC_BIT];
      en_q   <= CTRL_RST[CTRL_EN_BIT];
      ie_q   <= CTRL_RST[CTRL_IE_BIT];
      baud_q <= '0;
      ovr_q  <= 1'b0;
      idle_q <= 1'b1;
      irq_q  <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      bits_q <= bits_d;
      eedd_q <= eedd_d;
      eedc_q <= eedc_d;
      en_q   <= en_d;
      ie_q   <= ie_d;
      baud_q <= baud_d;
      ovr_q  <= ovr_d;
      idle_q <= rx_idle_i;
      irq_q  <= irq_d;
    end
  end

endmodule

// File: tb/tb_sia_rx_ctrl.sv
// Directed testbench for sia_rx_ctrl. Inputs change 1 ns after the rising
// edge; outputs are sampled at the same point, well clear of the edge.
module tb_sia_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [2:0]  adr = '0;
  logic [15:0] dat_w = '0;
  logic        ack;
  logic [15:0] dat_r;
  logic        stall;
  logic [4:0]  rx_bits;
  logic [31:0] rx_baud;
  logic        rx_eedd, rx_eedc, rx_reset;
  logic [15:0] rx_dat = '0;
  logic        rx_idle = 1'b1;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sia_rx_ctrl #(.FIFO_DEPTH(8), .SRW_BITS(16)) dut (
    .clk_i      (clk),
    .reset_ni   (rst_n),
    .cyc_i      (cyc),
    .stb_i      (stb),
    .we_i       (we),
    .adr_i      (adr),
    .dat_i      (dat_w),
    .ack_o      (ack),
    .dat_o      (dat_r),
    .stall_o    (stall),
    .rx_bits_o  (rx_bits),
    .rx_baud_o  (rx_baud),
    .rx_eedd_o  (rx_eedd),
    .rx_eedc_o  (rx_eedc),
    .rx_reset_o (rx_reset),
    .rx_dat_i   (rx_dat),
    .rx_idle_i  (rx_idle),
    .irq_o      (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
    tick;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input string tag, input logic [2:0] a, input logic [15:0] exp);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    tick;
    cyc = 1'b0; stb = 1'b0;
    check({tag, ".ack"}, 32'(ack), 32'd1);
    check(tag, 32'(dat_r), 32'(exp));
  endtask

  // Raw shift register for a 10-bit frame carrying data byte k:
  // start=0, 8 data bits, stop=1, left-aligned in 16 bits.
  function automatic logic [15:0] frame10(input logic [7:0] k);
    return {1'b1, k, 1'b0, 6'b0};
  endfunction

  // One receive cycle: idle low, then idle high with the shift register
  // loaded; one extra cycle lets the registered interrupt follow.
  task automatic send_frame(input logic [15:0] raw);
    rx_idle = 1'b0;
    tick;
    rx_idle = 1'b1; rx_dat = raw;
    tick;
    tick;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.ack", 32'(ack), 32'd0);
    check("rst.dat", 32'(dat_r), 32'd0);
    check("rst.irq", 32'(irq), 32'd0);
    check("rst.rx_reset", 32'(rx_reset), 32'd1);
    rst_n = 1'b1;
    tick;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.bits", 32'(rx_bits), 32'd10);
    check("rst.baud", rx_baud, 32'd0);
    wb_read("rst.ctrl", 3'd0, 16'h002A);
    wb_read("rst.status", 3'd4, 16'h0000);
    tick;
    check("ack.drop", 32'(ack), 32'd0);

    // Baud registers
    wb_write(3'd1, 16'h1234);
    wb_write(3'd2, 16'hABCD);
    check("baud.out", rx_baud, 32'hABCD_1234);
    wb_read("baud.l", 3'd1, 16'h1234);
    wb_read("baud.h", 3'd2, 16'hABCD);

    // BITS saturation plus EEDC/EEDD fields
    wb_write(3'd0, 16'h005F);
    wb_read("ctrl.sat", 3'd0, 16'h0050);
    check("ctrl.bits16", 32'(rx_bits), 32'd16);
    check("ctrl.eedc", 32'(rx_eedc), 32'd1);
    check("ctrl.eedd", 32'(rx_eedd), 32'd0);

    // Enable receiver with interrupts, 10-bit frames
    wb_write(3'd0, 16'hFF8A);
    wb_read("ctrl.en", 3'd0, 16'h018A);
    check("en.rx_reset", 32'(rx_reset), 32'd0);

    // Good frame
    send_frame(16'hAABF);
    check("good.irq", 32'(irq), 32'd1);
    wb_read("good.status", 3'd4, 16'h0001);
    wb_read("good.data", 3'd0 + 3'd3, 16'h0055);
    wb_read("good.status2", 3'd4, 16'h0000);
    check("good.irq_off", 32'(irq), 32'd0);

    // Stop bit clear -> framing error
    send_frame(16'h2ABF);
    wb_read("fe.data", 3'd3, 16'h8055);

    // Frame length below 3
    wb_write(3'd0, 16'h0182);
    send_frame(16'hFFFF);
    wb_read("short.data", 3'd3, 16'h8000);
    wb_write(3'd0, 16'h018A);

    // Empty DATA read and unmapped addresses
    wb_read("empty.data", 3'd3, 16'h0000);
    wb_write(3'd5, 16'hFFFF);
    wb_read("adr5", 3'd5, 16'h0000);
    wb_read("adr7", 3'd7, 16'h0000);

    // BUSY while receiving
    rx_idle = 1'b0;
    wb_read("busy.status", 3'd4, 16'h0008);
    rx_idle = 1'b1; rx_dat = frame10(8'h33);
    tick;
    tick;
    wb_read("busy.data", 3'd3, 16'h0033);

    // Overflow: nine frames into eight entries
    for (int k = 1; k <= 9; k++) send_frame(frame10(8'(k)));
    wb_read("ovr.status", 3'd4, 16'h0007);
    for (int k = 1; k <= 8; k++) wb_read($sformatf("ovr.data%0d", k), 3'd3, 16'(k));
    wb_read("ovr.status2", 3'd4, 16'h0004);
    wb_write(3'd4, 16'h0004);
    wb_read("ovr.clr", 3'd4, 16'h0000);

    // Pop and push in the same cycle while full
    for (int k = 0; k < 8; k++) send_frame(frame10(8'(8'h11 + k)));
    wb_read("pp.full", 3'd4, 16'h0003);
    rx_idle = 1'b0;
    tick;
    rx_idle = 1'b1; rx_dat = frame10(8'h42);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd3;
    tick;
    cyc = 1'b0; stb = 1'b0;
    check("pp.head", 32'(dat_r), 32'h11);
    wb_read("pp.status", 3'd4, 16'h0003);
    for (int k = 1; k < 8; k++) wb_read($sformatf("pp.data%0d", k), 3'd3, 16'(8'h11 + k));
    wb_read("pp.last", 3'd3, 16'h0042);
    wb_read("pp.empty", 3'd4, 16'h0000);

    // OVR clear and new overflow in the same cycle
    for (int k = 0; k < 8; k++) send_frame(frame10(8'(8'h21 + k)));
    rx_idle = 1'b0;
    tick;
    rx_idle = 1'b1; rx_dat = frame10(8'h29);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd4; dat_w = 16'h0004;
    tick;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wb_read("clrovf.status", 3'd4, 16'h0007);
    wb_write(3'd4, 16'h0004);
    for (int k = 0; k < 8; k++) wb_read($sformatf("clrovf.data%0d", k), 3'd3, 16'(8'h21 + k));
    wb_read("clrovf.status2", 3'd4, 16'h0000);

    // Disabling the receiver mid-frame
    rx_idle = 1'b0;
    tick;
    wb_write(3'd0, 16'h010A);
    check("dis.rx_reset", 32'(rx_reset), 32'd1);
    rx_idle = 1'b1; rx_dat = frame10(8'h77);
    tick;
    tick;
    wb_read("dis.status", 3'd4, 16'h0000);
    check("dis.irq", 32'(irq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
